// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, two write ports, scoreboard issue and
// clear request, grouped so that the requester (master) and the register
// file (slave) see opposite directions.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [1:0]            wr_en;
  logic [2*ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0]   wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-entry busy scoreboard and a
// sequential full-file clear (one entry per cycle).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and the resulting busy state) to the combinational read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clearing;

  logic [ADDR_W-1:0] wa0, wa1, ia;
  logic [DATA_W-1:0] wd0, wd1;
  logic              we0_eff, we1_eff, iss_eff;

  logic [DATA_W-1:0] mem_rd [DEPTH];
  logic [DEPTH-1:0]  busy_vec;

  // Address 0 is inert when the hard-wired zero register is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign clearing = (state_q == CLEAR);
  assign wa0      = bus.wr_addr[0 +: ADDR_W];
  assign wa1      = bus.wr_addr[ADDR_W +: ADDR_W];
  assign wd0      = bus.wr_data[0 +: DATA_W];
  assign wd1      = bus.wr_data[DATA_W +: DATA_W];
  assign ia       = bus.iss_addr;

  // Requests only count in IDLE and never against the zero register.
  assign we0_eff  = bus.wr_en[0] && !clearing && !is_zero(wa0);
  assign we1_eff  = bus.wr_en[1] && !clearing && !is_zero(wa1);
  assign iss_eff  = bus.iss_en   && !clearing && !is_zero(ia);

  assign bus.clr_busy = clearing;

  // Clear sequencer: walk the index from 0 to DEPTH-1, then return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign mem_rd[gi]   = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic [DATA_W-1:0] ent_q, ent_d;
        logic              bsy_q, bsy_d;
        logic              hit0, hit1;

        assign hit0 = we0_eff && (wa0 == IDX);
        assign hit1 = we1_eff && (wa1 == IDX);

        // Entry update: clear sweep, else write (port 1 wins), busy set by issue over clear by write.
        always_comb begin
          ent_d = ent_q;
          bsy_d = bsy_q;
          if (clearing) begin
            if (cnt_q == IDX) begin
              ent_d = '0;
              bsy_d = 1'b0;
            end
          end else begin
            if (hit1)      ent_d = wd1;
            else if (hit0) ent_d = wd0;
            if (hit0 || hit1)              bsy_d = 1'b0;
            if (iss_eff && (ia == IDX))    bsy_d = 1'b1;
          end
        end

        // Entry storage with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ent_q <= '0;
            bsy_q <= 1'b0;
          end else begin
            ent_q <= ent_d;
            bsy_q <= bsy_d;
          end
        end

        assign mem_rd[gi]   = ent_q;
        assign busy_vec[gi] = bsy_q;
      end
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdat;
      logic              rbsy;

      assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      // Combinational read; the clear sequence masks data to 0 and busy to 1.
      always_comb begin
        rdat = mem_rd[ra];
        rbsy = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
        if (we1_eff && (wa1 == ra)) begin
          rdat = wd1;
          rbsy = iss_eff && (ia == ra);
        end else if (we0_eff && (wa0 == ra)) begin
          rdat = wd0;
          rbsy = iss_eff && (ia == ra);
        end
`endif
        if (clearing) begin
          rdat = '0;
          rbsy = 1'b1;
        end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = rdat;
      assign bus.rd_busy[gi]                  = rbsy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, randomized
// traffic against a behavioural model, clear and reset-during-clear sequences.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus_if ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: architectural contents plus remaining clear cycles.
  logic [DW-1:0] ref_mem  [DEPTH];
  logic          ref_busy [DEPTH];
  int            clr_left;

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          iss;
    logic [AW-1:0] ia, ra0, ra1;
    logic [DW-1:0] ed0, ed1;
    logic          eb0, eb1;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a]  = '0;
      ref_busy[a] = 1'b0;
    end
    clr_left = 0;
  endtask

  function automatic logic [AW-1:0] rd_a(input int k);
    return bus_if.rd_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    logic [AW-1:0] a;
    a = rd_a(k);
    if (clr_left > 0) return '0;
    if (BYP && a != 0) begin
      if (bus_if.wr_en[1] && bus_if.wr_addr[AW +: AW] == a) return bus_if.wr_data[DW +: DW];
      if (bus_if.wr_en[0] && bus_if.wr_addr[0 +: AW] == a)  return bus_if.wr_data[0 +: DW];
    end
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input int k);
    logic [AW-1:0] a;
    a = rd_a(k);
    if (clr_left > 0) return 1'b1;
    if (BYP && a != 0 &&
        ((bus_if.wr_en[1] && bus_if.wr_addr[AW +: AW] == a) ||
         (bus_if.wr_en[0] && bus_if.wr_addr[0 +: AW] == a)))
      return bus_if.iss_en && bus_if.iss_addr == a;
    return ref_busy[a];
  endfunction

  // Apply the inputs currently on the bus to the model, as of the next edge.
  task automatic model_step();
    logic [AW-1:0] a0, a1;
    a0 = bus_if.wr_addr[0 +: AW];
    a1 = bus_if.wr_addr[AW +: AW];
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (bus_if.wr_en[0] && a0 != 0) begin ref_mem[a0] = bus_if.wr_data[0 +: DW];  ref_busy[a0] = 1'b0; end
      if (bus_if.wr_en[1] && a1 != 0) begin ref_mem[a1] = bus_if.wr_data[DW +: DW]; ref_busy[a1] = 1'b0; end
      if (bus_if.iss_en && bus_if.iss_addr != 0) ref_busy[bus_if.iss_addr] = 1'b1;
      if (bus_if.clr_req) begin
        model_reset();
        clr_left = DEPTH;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_data%0d@%0d", k, rd_a(k)), bus_if.rd_data[k*DW +: DW], exp_data(k));
      chk($sformatf("rd_busy%0d@%0d", k, rd_a(k)), 32'(bus_if.rd_busy[k]), 32'(exp_busy(k)));
    end
    chk("clr_busy", 32'(bus_if.clr_busy), 32'(clr_left > 0));
  endtask

  task automatic set_in(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1, input logic iss,
                        input logic [AW-1:0] ia, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic clr);
    bus_if.wr_en    = we;
    bus_if.wr_addr  = {wa1, wa0};
    bus_if.wr_data  = {wd1, wd0};
    bus_if.iss_en   = iss;
    bus_if.iss_addr = ia;
    bus_if.rd_addr  = {ra1, ra0};
    bus_if.clr_req  = clr;
  endtask

  task automatic set_idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    set_in(2'b00, '0, '0, '0, '0, 1'b0, '0, ra0, ra1, 1'b0);
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic set_random(input logic allow_clr);
    logic clr;
    clr = allow_clr && ($urandom_range(0, 63) == 0);
    set_in(2'($urandom_range(0, 3)), raddr(), raddr(), $urandom, $urandom,
           1'($urandom_range(0, 1)), raddr(), raddr(), raddr(), clr);
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a += 2) begin
      set_idle(AW'(a), AW'(a + 1));
      cycle();
    end
  endtask

  task automatic add_row(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                         input logic [DW-1:0] wd0, input logic [DW-1:0] wd1, input logic iss,
                         input logic [AW-1:0] ia, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic [DW-1:0] ed0, input logic [DW-1:0] ed1,
                         input logic eb0, input logic eb1);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.iss = iss; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
    tbl.push_back(v);
  endtask

  initial begin
    int hi;

    // Expected outputs are sampled in the same cycle the row's inputs are applied.
    add_row(2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 0, 5'd0, 5'd3, 5'd0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0);
    add_row(2'b01, 5'd0, 5'd0, 32'h1, 32'h0, 0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 0, 0);
    add_row(2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 0, 5'd0, 5'd0, 5'd7, 32'h0, BYP ? 32'h22 : 32'h0, 0, 0);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1, 5'd5, 5'd7, 5'd5, 32'h22, 32'h0, 0, 0);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd5, 5'd7, 32'h0, 32'h22, 1, 0);
    add_row(2'b01, 5'd5, 5'd0, 32'h55, 32'h0, 0, 5'd0, 5'd5, 5'd5, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, !BYP, !BYP);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd5, 5'd0, 32'h55, 32'h0, 0, 0);
    add_row(2'b01, 5'd5, 5'd0, 32'h66, 32'h0, 1, 5'd5, 5'd5, 5'd7, BYP ? 32'h66 : 32'h55, 32'h22, BYP, 0);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd5, 5'd7, 32'h66, 32'h22, 1, 0);
    add_row(2'b10, 5'd0, 5'd9, 32'h0, 32'hCAFE, 0, 5'd0, 5'd9, 5'd9, BYP ? 32'hCAFE : 32'h0, BYP ? 32'hCAFE : 32'h0, 0, 0);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd9, 5'd5, 32'hCAFE, 32'h66, 0, 1);
    add_row(2'b10, 5'd0, 5'd0, 32'h0, 32'h5, 1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0);
    add_row(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 5'd9, 32'h0, 32'hCAFE, 0, 0);

    // Reset: asynchronous, observed mid-cycle before any clock edge.
    set_idle(5'd3, 5'd7);
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    chk("reset_rd_data0", bus_if.rd_data[0 +: DW], 32'h0);
    chk("reset_rd_data1", bus_if.rd_data[DW +: DW], 32'h0);
    chk("reset_rd_busy", 32'(bus_if.rd_busy), 32'h0);
    chk("reset_clr_busy", 32'(bus_if.clr_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    foreach (tbl[i]) begin
      set_in(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
             tbl[i].iss, tbl[i].ia, tbl[i].ra0, tbl[i].ra1, 1'b0);
      @(negedge clk);
      $display("vec %0d: we=%b wa=%0d/%0d iss=%b@%0d ra=%0d/%0d -> rd=%h/%h busy=%b",
               i, tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].iss, tbl[i].ia,
               tbl[i].ra0, tbl[i].ra1, bus_if.rd_data[0 +: DW], bus_if.rd_data[DW +: DW], bus_if.rd_busy);
      chk($sformatf("vec%0d_rd0", i), bus_if.rd_data[0 +: DW], tbl[i].ed0);
      chk($sformatf("vec%0d_rd1", i), bus_if.rd_data[DW +: DW], tbl[i].ed1);
      chk($sformatf("vec%0d_busy0", i), 32'(bus_if.rd_busy[0]), 32'(tbl[i].eb0));
      chk($sformatf("vec%0d_busy1", i), 32'(bus_if.rd_busy[1]), 32'(tbl[i].eb1));
      model_step();
      @(posedge clk);
      #1;
    end

    // Randomized traffic with occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      set_random(1'b1);
      cycle();
    end
    // Let any clear started by the random phase run out.
    for (int n = 0; n < DEPTH + 2; n++) begin
      set_random(1'b0);
      cycle();
    end
    $display("random phase done");

    // Full clear: exactly DEPTH busy cycles, requests ignored, then all zero.
    set_in(2'b01, 5'd4, 5'd0, 32'h1234, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6, 1'b1);
    cycle();
    hi = 0;
    for (int n = 0; n < 100; n++) begin
      set_random(1'b1);
      @(negedge clk);
      check_all();
      if (!bus_if.clr_busy) break;
      hi++;
      model_step();
      @(posedge clk);
      #1;
    end
    chk("clear_length", 32'(hi), 32'(DEPTH));
    $display("clear sequence: clr_busy high for %0d cycles", hi);
    sweep();

    // First write and issue after the clear take effect normally.
    set_in(2'b01, 5'd4, 5'd0, 32'h44, 32'h0, 1'b1, 5'd8, 5'd4, 5'd8, 1'b0);
    cycle();
    set_idle(5'd4, 5'd8);
    @(negedge clk);
    chk("post_clear_write", bus_if.rd_data[0 +: DW], 32'h44);
    chk("post_clear_issue", 32'(bus_if.rd_busy[1]), 32'h1);
    model_step();
    @(posedge clk);
    #1;

    // Reset during clear aborts the sequence immediately.
    for (int n = 0; n < 8; n++) begin
      set_random(1'b0);
      cycle();
    end
    set_in(2'b00, '0, '0, '0, '0, 1'b0, '0, 5'd4, 5'd8, 1'b1);
    cycle();
    for (int n = 0; n < 10; n++) begin
      set_idle(5'd4, 5'd8);
      cycle();
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("abort_clr_busy", 32'(bus_if.clr_busy), 32'h0);
    chk("abort_rd_busy", 32'(bus_if.rd_busy), 32'h0);
    chk("abort_rd_data0", bus_if.rd_data[0 +: DW], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset during clear applied");
    sweep();

    for (int n = 0; n < 100; n++) begin
      set_random(1'b1);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, address 0 is a hard-wired zero register.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
REQ-009 SHALL have port rd_busy  out  NRD  scoreboard busy flag per read port.
REQ-010 SHALL have port wr_en  in  2  write enables, ports 0 and 1.
REQ-011 SHALL have port wr_addr  in  2*ADDR_W  write addresses.
REQ-012 SHALL have port wr_data  in  2*DATA_W  write data.
REQ-013 SHALL have port iss_en  in  1  mark iss_addr busy (pending producer).
REQ-014 SHALL have port iss_addr  in  ADDR_W  register being reserved.
REQ-015 SHALL have port clr_req  in  1  start a full-file clear sequence.
REQ-016 SHALL have port clr_busy  out  1  high while a clear sequence runs.

Function
REQ-017 Reads SHALL be combinational; rd_data[k] = mem[rd_addr[k]] with no clock delay.
REQ-018 With ZERO_REG=1, address 0 SHALL read 0, ignore writes and issues, and never report busy.
REQ-019 An enabled write SHALL update mem at the next rising edge.
REQ-020 When both write ports target the same address in one cycle, port 1 SHALL win.
REQ-021 Scoreboard: iss_en SHALL set busy[iss_addr] at the next edge; an enabled write SHALL clear busy[wr_addr] at the next edge.
REQ-022 Issue and write to the same address in one cycle SHALL leave busy set (new producer wins).
REQ-023 Without bypass, rd_busy[k] SHALL equal busy[rd_addr[k]].
REQ-024 FSM states: IDLE, CLEAR; IDLE->CLEAR on clr_req; CLEAR->IDLE after the entry at index DEPTH-1 is cleared.
REQ-025 In CLEAR, an index counter SHALL zero one entry and its busy bit per cycle, from 0 to DEPTH-1; a clear therefore takes exactly DEPTH cycles.
REQ-026 clr_busy SHALL be high exactly while in CLEAR.
REQ-027 In CLEAR, wr_en, iss_en and clr_req SHALL be ignored; rd_data SHALL read 0 and rd_busy SHALL read all ones.
REQ-028 The first write or issue accepted after CLEAR->IDLE SHALL take effect normally.

Reset
REQ-029 rst_n low SHALL immediately clear all mem entries and busy bits to 0, force FSM to IDLE, and reset the counter to 0.
REQ-030 After reset, rd_data SHALL be 0, rd_busy 0 and clr_busy 0.
REQ-031 Reset during CLEAR SHALL abort the sequence and return to IDLE with all state zero.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL compile write-to-read forwarding in or out.
REQ-033 With REGFILE_BYPASS_EN defined, a read address matching an enabled write in the same cycle SHALL return that wr_data, with port 1 taking priority; rd_busy for that address SHALL read 0 unless iss_en targets it in the same cycle.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL return only stored values and rd_busy SHALL be the raw busy bit.

Verification
REQ-035 Reset, write port 0 addr 3 = 0xDEADBEEF -> rd_data for addr 3 = 0xDEADBEEF one cycle later; addr 0 write 0x1 -> reads 0.
REQ-036 Both write ports to addr 7 (0x11 on port 0, 0x22 on port 1) -> addr 7 reads 0x22.
REQ-037 iss addr 5 -> rd_busy=1 next cycle; write addr 5 = 0x55 -> busy cleared; issue and write 5 in the same cycle -> busy stays 1.
REQ-038 Bypass build: same-cycle write 0xCAFE to addr 9 while reading 9 -> rd_data=0xCAFE, rd_busy=0; non-bypass build -> old value returned.
REQ-039 clr_req with ADDR_W=5 -> clr_busy high 32 cycles, writes ignored, then all entries read 0; rst_n low at cycle 10 -> clr_busy 0 immediately.
